aes_encryption: RTL and testbench
=================================

# aes_encryption

Iterative AES-256 encryption engine: the forward-direction counterpart of `aes_decryption`, using the same 256-bit key and 128-bit block format. It accepts one plaintext block and key through a valid/ready handshake and computes one round per cycle. The round keys are expanded on the fly, with no stored key schedule. The ciphertext is held until the consumer acknowledges it with `yumi_i`.

## Interface
- No parameters. Key size is fixed at 256 bits, 14 rounds.
- `clk_i` input 1: sole clock, rising edge.
- `reset_ni` input 1: asynchronous, active-low reset.
- `v_i` input 1: `key_i`/`plaintext_i` valid.
- `ready_o` output 1: engine idle, can accept a block.
- `key_i` input 256: cipher key; bits [255:248] are key byte 0.
- `plaintext_i` input 128: input block; bits [127:120] are byte 0, column-major state per FIPS-197.
- `v_o` output 1: `ciphertext_o` valid.
- `yumi_i` input 1: consumer takes ciphertext; legal only while `v_o`=1.
- `ciphertext_o` output 128: result; same byte order as `plaintext_i`.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: `ready_o`=1. When `v_i`=1, the block is accepted. At that edge the engine loads `state` ← `plaintext_i` ^ `key_i[255:128]`, `k_prev` ← `key_i[255:128]`, `k_cur` ← `key_i[127:0]`, sets `rnd` ← 1, and moves to RUN.
  - RUN: each edge performs round `rnd`.
    - Rounds 1–13: SubBytes, ShiftRows, MixColumns, then AddRoundKey(`k_cur`).
    - Round 14: same sequence but with MixColumns omitted.
    - Same edge: `k_prev` ← `k_cur`, `k_cur` ← expand(`k_prev`, `k_cur`, n=`rnd`+1), `rnd` ← `rnd`+1.
    - After round 14, go to DONE.
  - DONE: `v_o`=1. When `yumi_i`=1, go to IDLE.
- Key expansion, n = index of the round key being generated:
  - `t` = last word of `k_cur` (bits [31:0]).
  - n even: `t` ← SubWord(RotWord(`t`)) ^ {Rcon[n/2], 24'h0}, with Rcon[1..7] = 01,02,04,08,10,20,40.
  - n odd: `t` ← SubWord(`t`).
  - w0 = `k_prev`.w0 ^ `t`; each following wi = `k_prev`.wi ^ w(i-1).
  - Key words for n > 14 are computed but never used.
- S-boxes: 20 instances of the team's forward S-box (`aes_sbox`) — 16 for the datapath, 4 for SubWord.
- MixColumns uses xtime (multiply by x) in GF(2^8), reduction polynomial 0x11B.
- `ciphertext_o` is driven directly from `state` at all times; it is valid only when `v_o`=1.
- `rnd` is a 4-bit counter. It never wraps in operation and is cleared on accept.
- Input handling:
  - `key_i`/`plaintext_i` are sampled only at the accept edge; later changes are ignored.
  - `v_i` during RUN or DONE is not accepted (`ready_o`=0).
- `yumi_i` outside DONE is ignored.

## Timing
- Reset values (asynchronous): state IDLE; `ready_o`=1, `v_o`=0, `ciphertext_o`=0; `k_prev`, `k_cur`=0; `rnd`=0.
- Accept at edge E0. Rounds occur at E1–E14. `v_o` rises after E14, so the result is ready 14 cycles after acceptance.
- `yumi_i` sampled at edge Ey returns the engine to IDLE; `ready_o`=1 after Ey.
  - Minimum block period: 16 cycles.
  - No same-cycle accept with `yumi_i`.
- Reset asserted mid-RUN or mid-DONE: all registers clear immediately. No `v_o` is produced for the aborted block.

## Configuration
- Macro: `AES_ENC_ZEROIZE_EN`.
- Defined: the `yumi_i` edge also clears `state`, `k_prev` and `k_cur` to 0, so `ciphertext_o`=0 while IDLE.
- Undefined: registers keep their contents after `yumi_i`, and `ciphertext_o` holds the last ciphertext until the next accept.

## Test plan
- FIPS-197 C.3 vector: key 000102…1e1f, pt 00112233445566778899aabbccddeeff → `v_o` exactly 14 cycles after accept, ct 8ea2b7ca516745bfeafc49904b496089.
- Zero key, zero pt → ct dc95c078a2408989ad48a21492842087.
- SP800-38A vector, sent back-to-back after the previous `yumi_i`: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, pt 6bc1bee22e409f96e93d7e117393172a → ct f3eed1bdb5d2a03c064b5a7e3db181f8.
- Handshake corners:
  - Change `key_i`/`plaintext_i` and pulse `v_i` during RUN → result unchanged; `ready_o`=0 throughout.
  - Delay `yumi_i` 5 cycles → `v_o` and `ciphertext_o` stable all 5 cycles.
- Drop `reset_ni` at round 7 → all outputs 0 and `ready_o`=1 immediately. Restart with the C.3 vector → correct ct.
- With `AES_ENC_ZEROIZE_EN` defined → `ciphertext_o`=0 the cycle after `yumi_i`. Without it → the ct is retained.

Source files
------------

// File: rtl/aes_encryption.sv
// Iterative AES-256 encryption engine: one round per clock, round keys expanded on the fly.
// Optional build macro AES_ENC_ZEROIZE_EN wipes state and key registers when the result is taken.
module aes_encryption (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         v_i,
  output logic         ready_o,
  input  logic [255:0] key_i,
  input  logic [127:0] plaintext_i,
  output logic         v_o,
  input  logic         yumi_i,
  output logic [127:0] ciphertext_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e         fsm_reg, fsm_next;
  logic [127:0] state_reg, k_prev_reg, k_cur_reg;
  logic [3:0]   rnd_reg;

  logic [127:0] sb_flat, sr_flat, mc_flat, round_out;
  logic [31:0]  sw, t, w0, w1, w2, w3;
  logic [3:0]   n;
  logic [7:0]   rcon;
  logic         last_round;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as b^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      assign sb_flat[127-8*gi -: 8] = aes_sbox(state_reg[127-8*gi -: 8]);
    end
    // Byte gi sits at row gi%4, column gi/4; row r rotates left by r columns.
    for (gi = 0; gi < 16; gi++) begin : g_shift
      localparam int R = gi % 4;
      localparam int C = gi / 4;
      assign sr_flat[127-8*gi -: 8] = sb_flat[127-8*(R+4*((C+R)%4)) -: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_flat[127-32*gi -: 8];
      assign a1 = sr_flat[119-32*gi -: 8];
      assign a2 = sr_flat[111-32*gi -: 8];
      assign a3 = sr_flat[103-32*gi -: 8];
      assign mc_flat[127-32*gi -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                         a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                         a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                         xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    for (gi = 0; gi < 4; gi++) begin : g_subword
      assign sw[31-8*gi -: 8] = aes_sbox(k_cur_reg[31-8*gi -: 8]);
    end
  endgenerate

  assign last_round = (rnd_reg == 4'd14);
  assign round_out  = (last_round ? sr_flat : mc_flat) ^ k_cur_reg;

  // SubWord commutes with RotWord, so the even-index case rotates the substituted word.
  always_comb begin
    n    = rnd_reg + 4'd1;
    rcon = 8'h01 << (n[3:1] - 3'd1);
    if (n[0]) t = sw;
    else      t = {sw[23:0], sw[31:24]} ^ {rcon, 24'h000000};
    w0 = k_prev_reg[127:96] ^ t;
    w1 = k_prev_reg[95:64]  ^ w0;
    w2 = k_prev_reg[63:32]  ^ w1;
    w3 = k_prev_reg[31:0]   ^ w2;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) fsm_reg <= IDLE;
    else           fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_reg;
    ready_o  = 1'b0;
    v_o      = 1'b0;
    case (fsm_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) fsm_next = RUN;
      end
      RUN:  if (last_round) fsm_next = DONE;
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg  <= '0;
      k_prev_reg <= '0;
      k_cur_reg  <= '0;
      rnd_reg    <= '0;
    end else begin
      case (fsm_reg)
        IDLE: if (v_i) begin
          state_reg  <= plaintext_i ^ key_i[255:128];
          k_prev_reg <= key_i[255:128];
          k_cur_reg  <= key_i[127:0];
          rnd_reg    <= 4'd1;
        end
        RUN: begin
          state_reg  <= round_out;
          k_prev_reg <= k_cur_reg;
          k_cur_reg  <= {w0, w1, w2, w3};
          rnd_reg    <= rnd_reg + 4'd1;
        end
        DONE: begin
`ifdef AES_ENC_ZEROIZE_EN
          if (yumi_i) begin
            state_reg  <= '0;
            k_prev_reg <= '0;
            k_cur_reg  <= '0;
          end
`else
          state_reg <= state_reg;
`endif
        end
        default: ;
      endcase
    end
  end

  assign ciphertext_o = state_reg;

endmodule

// File: tb/tb_aes_encryption.sv
// Scoreboard bench for aes_encryption: driver pushes expected ciphertexts, monitor pops on v_o.
module tb_aes_encryption;

  logic         clk_i = 1'b0;
  logic         reset_ni = 1'b1;
  logic         v_i = 1'b0;
  logic         yumi_i = 1'b0;
  logic [255:0] key_i = '0;
  logic [127:0] plaintext_i = '0;
  logic         ready_o, v_o;
  logic [127:0] ciphertext_o;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t[256];

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] Z_CT   = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [255:0] SP_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] SP_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP_CT  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

  always #5 clk_i = ~clk_i;

  aes_encryption dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .key_i        (key_i),
    .plaintext_i  (plaintext_i),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .ciphertext_o (ciphertext_o)
  );

  task automatic check128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model (FIPS-197, byte arrays) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [255:0] key, input logic [127:0] pt);
    logic [31:0] w[60];
    logic [7:0]  s[16], t[16];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) tmp = subw(tmp);
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row+4*col] = t[row+4*((col+row)%4)];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic       v_seen;
    logic [127:0] e;
    int txn;
    v_seen = 1'b0;
    txn = 0;
    forever begin
      @(negedge clk_i);
      if (v_o && !v_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_v_o: got ct %h, expected no output", ciphertext_o);
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d: ct=%h exp=%h", txn, ciphertext_o, e);
          check128("ciphertext", ciphertext_o, e);
        end
        txn++;
      end
      v_seen = v_o;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [255:0] k, input logic [127:0] p, input logic [127:0] e);
    int w;
    w = 0;
    while (!ready_o && w < 40) begin
      @(negedge clk_i);
      w++;
    end
    check_int("ready_before_send", int'(ready_o), 1);
    key_i = k;
    plaintext_i = p;
    v_i = 1'b1;
    exp_q.push_back(e);
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!v_o && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic consume(input int delay, input logic [127:0] e);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      check_int("hold_v_o", int'(v_o), 1);
      check128("hold_ct", ciphertext_o, e);
    end
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    check_int("ready_after_yumi", int'(ready_o), 1);
    check_int("v_o_after_yumi", int'(v_o), 0);
`ifdef AES_ENC_ZEROIZE_EN
    check128("zeroized_ct", ciphertext_o, 128'h0);
`else
    check128("retained_ct", ciphertext_o, e);
`endif
  endtask

  task automatic run_block(input logic [255:0] k, input logic [127:0] p,
                           input logic [127:0] e, input int delay);
    int cyc;
    send(k, p, e);
    wait_done(cyc);
    check_int("latency", cyc, 14);
    consume(delay, e);
  endtask

  initial begin
    logic [255:0] rk;
    logic [127:0] rp, re;
    int cyc;
    build_sbox();
    reset_ni = 1'b0;
    #1;
    check_int("reset_ready", int'(ready_o), 1);
    check_int("reset_v_o", int'(v_o), 0);
    check128("reset_ct", ciphertext_o, 128'h0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;

    run_block(C3_KEY, C3_PT, C3_CT, 0);
    run_block('0, '0, Z_CT, 1);
    run_block(SP_KEY, SP_PT, SP_CT, 0);

    // Inputs wiggle and v_i pulses during RUN must not disturb the block in flight.
    rk = rand256(); rp = rand128(); re = ref_enc(rk, rp);
    send(rk, rp, re);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk_i);
      check_int("ready_in_run", int'(ready_o), 0);
      key_i = rand256();
      plaintext_i = rand128();
      v_i = 1'($urandom_range(0, 1));
    end
    v_i = 1'b0;
    wait_done(cyc);
    check_int("run_latency", cyc, 1);
    consume(5, re);

    // Abort at round 7.
    send(C3_KEY, C3_PT, C3_CT);
    repeat (7) @(negedge clk_i);
    reset_ni = 1'b0;
    #1;
    check_int("abort_ready", int'(ready_o), 1);
    check_int("abort_v_o", int'(v_o), 0);
    check128("abort_ct", ciphertext_o, 128'h0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk_i);
    check_int("abort_hold_v_o", int'(v_o), 0);
    reset_ni = 1'b1;
    run_block(C3_KEY, C3_PT, C3_CT, 2);

    for (int b = 0; b < 6; b++) begin
      rk = rand256(); rp = rand128(); re = ref_enc(rk, rp);
      run_block(rk, rp, re, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk_i);
    check_int("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
